pc_sequencer: RTL and testbench

Program-counter and control-flow sequencer for the MIPS single-cycle core. It consumes the ALU `zero` flag, the decoded branch/jump controls and the immediate fields, and owns the architectural PC register. It computes branch and jump targets, applies redirects and honours pipeline stalls. An optional branch-delay-slot mode and a saturating taken-redirect counter are included. It sits between the ALU/decoder and instruction memory address input.

---
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and control-flow sequencer for the MIPS
// single-cycle core. Owns the architectural PC, computes BEQ/J targets and
// applies redirects, honouring stalls.
//
// Optional feature: define MIPS_DELAY_SLOT_EN to enable the branch-delay-slot
// mode (RUN/DELAY FSM plus a latched redirect target). Without it redirects
// apply on the deciding edge and delay_slot is tied low.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   stall              hold PC and all state; control inputs ignored
//   branch, alu_zero   BEQ decode and ALU zero flag (taken when zero == 0)
//   imm[15:0]          branch word offset, two's complement
//   jump, jump_target  J decode and 26-bit target field
//   pc[31:0]           registered fetch address
//   pc_plus4[31:0]     combinational pc + 4
//   taken              one-cycle pulse when pc first shows a redirect target
//   delay_slot         pc addresses a delay-slot instruction
//   taken_count[15:0]  saturating count of accepted redirect decisions
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic [15:0] imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        delay_slot,
  output logic [15:0] taken_count
);

  logic [31:0] br_target, j_target, redir_target;
  logic        redirect, cnt_sat;
  logic [31:0] pc_d;
  logic        taken_d;
  logic [15:0] cnt_d;

  assign pc_plus4     = pc + 32'd4;
  assign br_target    = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign j_target     = {pc_plus4[31:28], jump_target, 2'b00};
  // The BEQ compare reports equality as result 1, so zero == 0 means taken.
  assign redirect     = jump | (branch & ~alu_zero);
  assign redir_target = jump ? j_target : br_target;
  assign cnt_sat      = &taken_count;

`ifdef MIPS_DELAY_SLOT_EN
  typedef enum logic {RUN, DELAY} state_t;
  state_t      state, state_d;
  logic [31:0] tgt, tgt_d;
  logic        ds_q, ds_d;

  always_comb begin
    state_d = state;
    tgt_d   = tgt;
    pc_d    = pc;
    taken_d = 1'b0;
    ds_d    = ds_q;
    cnt_d   = taken_count;
    if (!stall) begin
      case (state)
        RUN: begin
          pc_d = pc_plus4;
          ds_d = 1'b0;
          if (redirect) begin
            // Fetch the slot instruction first; the target waits in tgt.
            tgt_d   = redir_target;
            ds_d    = 1'b1;
            state_d = DELAY;
            if (!cnt_sat) cnt_d = taken_count + 16'd1;
          end
        end
        DELAY: begin
          // Control inputs belong to the slot instruction and are ignored.
          pc_d    = tgt;
          taken_d = 1'b1;
          ds_d    = 1'b0;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      tgt   <= 32'd0;
      ds_q  <= 1'b0;
    end else begin
      state <= state_d;
      tgt   <= tgt_d;
      ds_q  <= ds_d;
    end
  end

  assign delay_slot = ds_q;
`else
  always_comb begin
    pc_d    = pc;
    taken_d = 1'b0;
    cnt_d   = taken_count;
    if (!stall) begin
      pc_d    = redirect ? redir_target : pc_plus4;
      taken_d = redirect;
      if (redirect && !cnt_sat) cnt_d = taken_count + 16'd1;
    end
  end

  assign delay_slot = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      taken       <= 1'b0;
      taken_count <= 16'd0;
    end else begin
      pc          <= pc_d;
      taken       <= taken_d;
      taken_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch = 1'b0, alu_zero = 1'b0, jump = 1'b0;
  logic [15:0] imm = 16'd0;
  logic [25:0] jump_target = 26'd0;
  logic [31:0] pc, pc_plus4;
  logic        taken, delay_slot;
  logic [15:0] taken_count;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch),
    .alu_zero(alu_zero), .imm(imm), .jump(jump), .jump_target(jump_target),
    .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .delay_slot(delay_slot),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        ds;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference state: architectural view only.
  logic [31:0] m_pc, m_tgt;
  logic        m_taken, m_ds, m_pend;
  logic [15:0] m_cnt;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      chk("taken", {31'd0, taken}, {31'd0, e.taken});
      chk("delay_slot", {31'd0, delay_slot}, {31'd0, e.ds});
      chk("taken_count", {16'd0, taken_count}, {16'd0, e.cnt});
    end
  end

  function automatic void model_reset();
    m_pc = RST_PC; m_tgt = 32'd0; m_taken = 1'b0; m_ds = 1'b0;
    m_pend = 1'b0; m_cnt = 16'd0;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.pc = m_pc; e.taken = m_taken; e.ds = m_ds; e.cnt = m_cnt;
    q.push_back(e);
  endfunction

  function automatic void model_step(input logic st, input logic br, input logic az,
                                     input logic [15:0] im, input logic jp,
                                     input logic [25:0] jt);
    logic signed [31:0] off;
    logic [31:0] tgt;
    logic        redir;
    if (st) begin
      m_taken = 1'b0;
      return;
    end
`ifdef MIPS_DELAY_SLOT_EN
    if (m_pend) begin
      m_pc = m_tgt; m_taken = 1'b1; m_ds = 1'b0; m_pend = 1'b0;
      return;
    end
`endif
    off   = $signed(im);
    redir = jp || (br && !az);
    tgt   = jp ? (((m_pc + 32'd4) & 32'hF000_0000) | (32'(jt) << 2))
               : (m_pc + 32'd4 + 32'(off * 4));
    if (redir && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`ifdef MIPS_DELAY_SLOT_EN
    m_pc = m_pc + 32'd4; m_taken = 1'b0; m_ds = redir;
    if (redir) begin m_tgt = tgt; m_pend = 1'b1; end
`else
    m_pc = redir ? tgt : m_pc + 32'd4;
    m_taken = redir;
`endif
  endfunction

  task automatic step(input logic st, input logic br, input logic az,
                      input logic [15:0] im, input logic jp, input logic [25:0] jt);
    @(negedge clk);
    #1;
    stall = st; branch = br; alu_zero = az; imm = im; jump = jp; jump_target = jt;
    model_step(st, br, az, im, jp, jt);
    push_exp();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    stall = 1'b1;
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_delay_slot", {31'd0, delay_slot}, 32'd0);
    chk("rst_taken_count", {16'd0, taken_count}, 32'd0);
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;   // first edge after release is a stall edge
    model_step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
    push_exp();
  endtask

  task automatic goto(input logic [31:0] t);
    int n;
    logic [31:0] nxt, d;
    n = 0;
    while (m_pc != t && n < 5000) begin
      nxt = m_pc + 32'd4;
      d   = t - nxt;
      if ($signed(d) >= -32'sh20000 && $signed(d) <= 32'sh1FFFC && d[1:0] == 2'b00)
        step(1'b0, 1'b1, 1'b0, d[17:2], 1'b0, 26'd0);
      else if (t[31:28] == nxt[31:28])
        step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, t[27:2]);
      else if ($signed(d) > 0)
        step(1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0, 26'd0);
      else
        step(1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 26'd0);
      n++;
    end
    chk("goto_reached", m_pc, t);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    model_reset();
    do_reset();
    // Sequential fetch from reset: 0x0040_0004, 08, 0C, 10.
    repeat (4) idle();
    // Taken BEQ back by 4 words from 0x0040_0010.
    step(1'b0, 1'b1, 1'b0, 16'hFFFC, 1'b0, 26'd0);
    idle(); idle();
    // Not-taken BEQ from 0x0040_0010.
    goto(32'h0040_0010);
    step(1'b0, 1'b1, 1'b1, 16'hFFFC, 1'b0, 26'd0);
    idle();
    // Wrap-around at the top of the address space.
    goto(32'hFFFF_FFFC);
    idle(); idle();
    // Jump beats a simultaneous taken branch.
    goto(32'h1000_0008);
    step(1'b0, 1'b1, 1'b0, 16'h0123, 1'b1, 26'h40);
    idle(); idle();
    // Redirect offered while stalled must be dropped.
    step(1'b1, 1'b1, 1'b0, 16'h0010, 1'b1, 26'h123);
    step(1'b1, 1'b1, 1'b0, 16'h0010, 1'b0, 26'h0);
    idle();
    // Redirect followed by stalls (DELAY hold in slot mode).
    step(1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 26'd0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
    step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0);
    idle(); idle();
    // Randomized control traffic.
    for (int i = 0; i < 400; i++)
      step(($urandom % 5) == 0, $urandom % 2, $urandom % 2, 16'($urandom),
           ($urandom % 4) == 0, 26'($urandom));
    // Reset right after a redirect: the pending target must be discarded.
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'h3FF_FFFF);
    do_reset();
    repeat (3) idle();
    // Saturation of the redirect counter.
    n = 0;
    while (m_cnt != 16'hFFFF && n < 140000) begin
      step(1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 26'($urandom));
      n++;
    end
    chk("sat_reached", {16'd0, m_cnt}, 32'h0000_FFFF);
    repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 26'h100);
    repeat (2) idle();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
